// File: rtl/msrh_l2_req_arbiter.sv
// L2 command-port arbiter: round-robin grant, tag allocation, response routing by tag.
// Optional per-requester perf counters are enabled with `define MSRH_L2_ARB_PERF_EN.
package msrh_pkg;
  localparam int L2_CMD_TAG_W = 4;

  typedef struct packed {
    logic [1:0]              cmd;
    logic [31:0]             addr;
    logic [L2_CMD_TAG_W-1:0] tag;
    logic [31:0]             data;
  } l2_req_t;

  typedef struct packed {
    logic [L2_CMD_TAG_W-1:0] tag;
    logic [31:0]             data;
  } l2_resp_t;
endpackage

module msrh_l2_req_arbiter
  import msrh_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int TAG_W = msrh_pkg::L2_CMD_TAG_W
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  l2_req_t [N_REQ-1:0]  i_req,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic [TAG_W-1:0]     o_req_tag,
  output logic                 o_l2_req_valid,
  output l2_req_t              o_l2_req,
  input  logic                 i_l2_req_ready,
  input  logic                 i_l2_resp_valid,
  input  l2_resp_t             i_l2_resp,
  output logic [N_REQ-1:0]     o_resp_valid,
  output l2_resp_t             o_resp,
  output logic                 o_tag_full,
  output logic                 o_err_unexp_resp
`ifdef MSRH_L2_ARB_PERF_EN
  ,
  output logic [N_REQ*32-1:0]  o_perf_grant_cnt,
  output logic [N_REQ*32-1:0]  o_perf_stall_cnt
`endif
);

  localparam int NTAG = 1 << TAG_W;
  localparam int OW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [NTAG-1:0]  tag_busy;
  logic [OW-1:0]    tag_owner [NTAG];
  logic [OW-1:0]    rr_ptr;
  logic             vld_p1;
  l2_req_t          req_p1;
  logic             err_unexp;

  logic             found;
  logic [OW-1:0]    winner;
  logic [TAG_W-1:0] free_tag;
  logic             grant;
  logic             resp_hit;
  logic             resp_miss;
  l2_req_t          grant_req_p0;
  logic [OW-1:0]    rr_next;

  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && i_req_valid[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

  // Lowest-index free tag; a tag freed this cycle is still busy here.
  always_comb begin
    free_tag = '0;
    for (int t = NTAG - 1; t >= 0; t--) begin
      if (!tag_busy[t]) free_tag = TAG_W'(t);
    end
  end

  assign o_tag_full = &tag_busy;
  assign grant      = i_reset_n && found && !o_tag_full && (!vld_p1 || i_l2_req_ready);
  assign o_req_tag  = free_tag;
  assign rr_next    = (winner == OW'(N_REQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    o_req_ready = '0;
    if (grant) o_req_ready[winner] = 1'b1;
  end

  always_comb begin
    grant_req_p0     = i_req[winner];
    grant_req_p0.tag = free_tag;
  end

  assign resp_hit  = i_reset_n && i_l2_resp_valid && tag_busy[i_l2_resp.tag];
  assign resp_miss = i_reset_n && i_l2_resp_valid && !tag_busy[i_l2_resp.tag];
  assign o_resp    = i_l2_resp;

  always_comb begin
    o_resp_valid = '0;
    if (resp_hit) o_resp_valid[tag_owner[i_l2_resp.tag]] = 1'b1;
  end

  // p0 -> p1: control state with reset
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      tag_busy  <= '0;
      rr_ptr    <= '0;
      vld_p1    <= 1'b0;
      err_unexp <= 1'b0;
    end else begin
      if (resp_hit) tag_busy[i_l2_resp.tag] <= 1'b0;
      if (grant) begin
        tag_busy[free_tag] <= 1'b1;
        rr_ptr             <= rr_next;
        vld_p1             <= 1'b1;
      end else if (i_l2_req_ready) begin
        vld_p1 <= 1'b0;
      end
      if (resp_miss) err_unexp <= 1'b1;
    end
  end

  // p0 -> p1: datapath and owner table, no reset
  always_ff @(posedge i_clk) begin
    if (grant) begin
      req_p1              <= grant_req_p0;
      tag_owner[free_tag] <= winner;
    end
  end

  assign o_l2_req_valid   = vld_p1;
  assign o_l2_req         = req_p1;
  assign o_err_unexp_resp = err_unexp;

`ifdef MSRH_L2_ARB_PERF_EN
  logic [31:0] grant_cnt [N_REQ];
  logic [31:0] stall_cnt [N_REQ];

  always_ff @(posedge i_clk) begin
    for (int r = 0; r < N_REQ; r++) begin
      if (!i_reset_n) begin
        grant_cnt[r] <= '0;
        stall_cnt[r] <= '0;
      end else begin
        if (o_req_ready[r]) grant_cnt[r] <= grant_cnt[r] + 32'd1;
        if (i_req_valid[r] && !o_req_ready[r]) stall_cnt[r] <= stall_cnt[r] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_perf
    assign o_perf_grant_cnt[g*32 +: 32] = grant_cnt[g];
    assign o_perf_stall_cnt[g*32 +: 32] = stall_cnt[g];
  end
`endif

endmodule

// File: tb/tb_msrh_l2_req_arbiter.sv
// Randomized bench for msrh_l2_req_arbiter against a tag-pool reference model.
module tb_msrh_l2_req_arbiter;
  import msrh_pkg::*;

  localparam int N = 2;
  localparam int NT = 16;

  logic                i_clk = 1'b0;
  logic                i_reset_n;
  logic [N-1:0]        i_req_valid;
  l2_req_t [N-1:0]     i_req;
  logic [N-1:0]        o_req_ready;
  logic [3:0]          o_req_tag;
  logic                o_l2_req_valid;
  l2_req_t             o_l2_req;
  logic                i_l2_req_ready;
  logic                i_l2_resp_valid;
  l2_resp_t            i_l2_resp;
  logic [N-1:0]        o_resp_valid;
  l2_resp_t            o_resp;
  logic                o_tag_full;
  logic                o_err_unexp_resp;

  msrh_l2_req_arbiter #(.N_REQ(N), .TAG_W(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_req_valid(i_req_valid), .i_req(i_req),
    .o_req_ready(o_req_ready), .o_req_tag(o_req_tag),
    .o_l2_req_valid(o_l2_req_valid), .o_l2_req(o_l2_req),
    .i_l2_req_ready(i_l2_req_ready),
    .i_l2_resp_valid(i_l2_resp_valid), .i_l2_resp(i_l2_resp),
    .o_resp_valid(o_resp_valid), .o_resp(o_resp),
    .o_tag_full(o_tag_full), .o_err_unexp_resp(o_err_unexp_resp)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: set of outstanding tags with owners, a fairness pointer,
  // and a single-entry output slot.
  bit      m_busy [NT];
  int      m_owner [NT];
  int      m_rr;
  bit      m_ovld;
  l2_req_t m_oreq;
  bit      m_err;

  function automatic void model_reset();
    for (int t = 0; t < NT; t++) m_busy[t] = 0;
    m_rr = 0;
    m_ovld = 0;
    m_err = 0;
  endfunction

  initial begin
    int     busy_cnt, w, ftag, pick, mode, n_busy;
    bit     grant, hit;
    logic [N-1:0] exp_ready, exp_rv;

    i_reset_n = 1'b0;
    i_req_valid = '0;
    i_req = '0;
    i_l2_req_ready = 1'b1;
    i_l2_resp_valid = 1'b0;
    i_l2_resp = '0;
    repeat (2) @(posedge i_clk);
    model_reset();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge i_clk);
      mode = (cyc / 150) % 5;
      i_reset_n = ($urandom_range(0, 199) != 0) || cyc < 10;
      for (int r = 0; r < N; r++) begin
        i_req_valid[r] = ($urandom_range(0, 99) < 70);
        i_req[r].cmd  = 2'($urandom);
        i_req[r].addr = $urandom;
        i_req[r].tag  = 4'($urandom);
        i_req[r].data = $urandom;
      end
      i_l2_req_ready = (mode == 2) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 85);
      n_busy = 0;
      for (int t = 0; t < NT; t++) if (m_busy[t]) n_busy++;
      i_l2_resp_valid = 1'b0;
      i_l2_resp.data = $urandom;
      i_l2_resp.tag = 4'($urandom);
      if (mode == 3 && $urandom_range(0, 99) < 20) begin
        i_l2_resp_valid = 1'b1;
      end else if (n_busy > 0 && $urandom_range(0, 99) < ((mode == 1) ? 5 : 50)) begin
        pick = $urandom_range(0, n_busy - 1);
        for (int t = 0; t < NT; t++) begin
          if (m_busy[t]) begin
            if (pick == 0) i_l2_resp.tag = 4'(t);
            pick--;
          end
        end
        i_l2_resp_valid = 1'b1;
      end
      #1;

      busy_cnt = 0;
      ftag = -1;
      for (int t = 0; t < NT; t++) begin
        if (m_busy[t]) busy_cnt++;
        else if (ftag < 0) ftag = t;
      end
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && i_req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
      end
      grant = i_reset_n && (w >= 0) && (busy_cnt < NT) && (!m_ovld || i_l2_req_ready);
      exp_ready = '0;
      if (grant) exp_ready[w] = 1'b1;
      hit = i_reset_n && i_l2_resp_valid && m_busy[i_l2_resp.tag];
      exp_rv = '0;
      if (hit) exp_rv[m_owner[i_l2_resp.tag]] = 1'b1;

      check_val("req_ready", 128'(o_req_ready), 128'(exp_ready));
      if (grant) check_val("req_tag", 128'(o_req_tag), 128'(ftag));
      check_val("tag_full", 128'(o_tag_full), 128'(busy_cnt == NT));
      check_val("l2_req_valid", 128'(o_l2_req_valid), 128'(m_ovld));
      if (m_ovld) check_val("l2_req", 128'(o_l2_req), 128'(m_oreq));
      check_val("resp_valid", 128'(o_resp_valid), 128'(exp_rv));
      if (hit) check_val("resp", 128'(o_resp), 128'(i_l2_resp));
      check_val("err_unexp", 128'(o_err_unexp_resp), 128'(m_err));

      if (!i_reset_n) begin
        model_reset();
      end else begin
        if (i_l2_resp_valid) begin
          if (m_busy[i_l2_resp.tag]) m_busy[i_l2_resp.tag] = 0;
          else m_err = 1;
        end
        if (grant) begin
          m_busy[ftag] = 1;
          m_owner[ftag] = w;
          m_rr = (w + 1) % N;
          m_ovld = 1;
          m_oreq = i_req[w];
          m_oreq.tag = 4'(ftag);
        end else if (i_l2_req_ready) begin
          m_ovld = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/msrh_l2_req_arbiter.md
Name: msrh_l2_req_arbiter

Overview:
- Shares the single L2 command port between N_REQ requesters: ICache refill is requester 0, DCache miss/writeback is requester 1.
- Round-robin arbitration feeds one registered output stage toward L2.
- Allocates L2 command tags from a pool of 2^L2_CMD_TAG_W entries and records the owner of each tag.
- Routes each L2 response back to the owning requester by tag, then frees the tag.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- TAG_W, msrh_pkg::L2_CMD_TAG_W (4), tag width; tag pool size = 2^TAG_W = 16.

Ports:
- i_clk  input  1  clock
- i_reset_n  input  1  synchronous active-low reset
- i_req_valid  input  N_REQ  per-requester request valid
- i_req  input  N_REQ x msrh_pkg::l2_req_t  per-requester command; the tag field is ignored
- o_req_ready  output  N_REQ  per-requester accept
- o_req_tag  output  TAG_W  tag assigned to the request accepted this cycle
- o_l2_req_valid  output  1  command valid toward L2
- o_l2_req  output  msrh_pkg::l2_req_t  command toward L2, tag field overwritten with the allocated tag
- i_l2_req_ready  input  1  L2 accepts command
- i_l2_resp_valid  input  1  L2 response valid; always accepted
- i_l2_resp  input  msrh_pkg::l2_resp_t  response tag and data
- o_resp_valid  output  N_REQ  one-hot response valid to the owning requester
- o_resp  output  msrh_pkg::l2_resp_t  response payload, broadcast to all requesters
- o_tag_full  output  1  all tags outstanding
- o_err_unexp_resp  output  1  sticky: response received for a tag not outstanding

Behaviour:
- State held: tag_busy[2^TAG_W], tag_owner[2^TAG_W] (clog2(N_REQ) bits each), rr_ptr, output register (valid + l2_req_t), sticky error flag.
- Reset (sync, i_reset_n=0):
  - tag_busy all 0, rr_ptr=0.
  - o_l2_req_valid=0, o_err_unexp_resp=0, o_resp_valid=0.
  - o_req_ready=0 during reset.
  - A reset mid-operation discards outstanding tags and any pending output command; late responses after reset set o_err_unexp_resp.
- Grant conditions (all must hold):
  - the output stage can load, i.e. (!o_l2_req_valid | i_l2_req_ready);
  - at least one tag is free (!o_tag_full);
  - at least one i_req_valid is asserted.
- Winner selection: first asserted requester searching from rr_ptr upward with wrap. o_req_ready is one-hot on the winner, combinational in the same cycle; zero when there is no grant.
- Tag allocation: lowest-index free tag, driven on o_req_tag in the grant cycle.
- On grant, at the clock edge:
  - output register loads i_req[winner] with tag replaced; o_l2_req_valid=1.
  - tag_busy[tag]=1, tag_owner[tag]=winner.
  - rr_ptr = winner+1 mod N_REQ.
- Latency: accepted request appears on o_l2_req_valid the next cycle. Back-to-back grants are allowed every cycle while L2 stays ready.
- Output hold: o_l2_req_valid and o_l2_req stay stable until i_l2_req_ready. If drained with no new grant, o_l2_req_valid=0 next cycle.
- Response path (combinational):
  - if i_l2_resp_valid and tag_busy[tag]: o_resp_valid[tag_owner[tag]]=1, o_resp=i_l2_resp; tag_busy[tag] clears at the clock edge.
  - a freed tag is not reusable in the same cycle; it becomes allocatable the next cycle.
  - if i_l2_resp_valid and !tag_busy[tag]: no o_resp_valid, o_err_unexp_resp set and held until reset.
- Simultaneous grant and response in one cycle: both take effect. The freed tag is never the tag allocated that cycle.
- o_tag_full = &tag_busy, computed from registered state.
- Every command, including stores, receives exactly one response.

Optional Feature:
- Macro: MSRH_L2_ARB_PERF_EN.
- With the macro defined, add outputs:
  - o_perf_grant_cnt: N_REQ x 32, per-requester grant counters.
  - o_perf_stall_cnt: N_REQ x 32, per-requester counters incremented each cycle i_req_valid=1 and o_req_ready=0.
  - Counters wrap at 2^32 and reset to 0.
- Without the macro: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single request: requester 0 valid with L2 always ready -> ready same cycle, o_req_tag=0; o_l2_req_valid next cycle with tag 0; response tag 0 -> o_resp_valid=2'b01, tag 0 free the following cycle.
- Fairness: both requesters valid continuously for 6 cycles, L2 always ready -> grant order 0,1,0,1,0,1; tags 0..5 in order.
- Tag exhaustion: 16 grants with no responses -> o_tag_full=1, o_req_ready=0. Response for tag 7 -> next cycle one grant with o_req_tag=7.
- Backpressure: i_l2_req_ready=0 for 3 cycles with o_l2_req_valid=1 -> o_l2_req stable, no new grants; ready=1 -> drain, and a new grant occurs in that same cycle.
- Unexpected response: response with tag 3 while tag 3 is not outstanding -> o_resp_valid=0, o_err_unexp_resp=1 and held until reset.
- Reset mid-flight: 4 tags outstanding, i_reset_n=0 for 1 cycle -> o_tag_full=0, o_l2_req_valid=0, next grant uses tag 0 and requester 0 wins first.
